// File: rtl/instr_byte_loader.sv
// Instruction-memory byte loader: de-frames an escaped byte stream, packs 32-bit words
// little-endian, and holds the CPU in reset until a clean load. Optional: INSTR_LOADER_CHECKSUM_EN.
module instr_byte_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              cpu_rst_o
);

  localparam logic [7:0]      B_ESC   = 8'hFD;
  localparam logic [7:0]      B_START = 8'hFE;
  localparam logic [7:0]      B_END   = 8'hFF;
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ESC, S_DONE, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ESC, S_DONE} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic [31:0]         r_asm, w_asm_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic [ADDR_W:0]     r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
  logic                w_clear, w_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum, w_csum_nxt;
`endif

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_asm   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_asm   <= w_asm_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_asm_nxt   = r_asm;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_clear     = 1'b0;
    w_data      = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif

    if (byte_valid_i) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (byte_i == B_START) begin
            w_clear     = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          if (byte_i == B_ESC) begin
            w_state_nxt = S_ESC;
          end else if (byte_i == B_START) begin
            w_clear = 1'b1;
          end else if (byte_i == B_END) begin
            if (r_idx != 2'd0) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              w_state_nxt = S_CHK;
`else
              w_state_nxt = S_DONE;
`endif
            end
          end else begin
            w_data = 1'b1;
          end
        end
        S_ESC: begin
          w_data      = 1'b1;
          w_state_nxt = S_LOAD;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK: begin
          // checksum byte is taken raw, so FD/FE/FF here are just values
          if (byte_i != r_csum) w_err_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
        default: ;
      endcase
    end

    if (w_clear) begin
      w_cnt_nxt = '0;
      w_err_nxt = 1'b0;
      w_idx_nxt = '0;
      w_asm_nxt = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      w_csum_nxt = '0;
`endif
    end

    if (w_data) begin
      w_asm_nxt[{r_idx, 3'b000} +: 8] = byte_i;
      w_idx_nxt = r_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      w_csum_nxt = r_csum ^ byte_i;
`endif
      if (r_idx == 2'd3) begin
        // full word: strobe next cycle unless memory is already full
        if (r_cnt == L_DEPTH) begin
          w_err_nxt = 1'b1;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_cnt[ADDR_W-1:0];
          w_wdata_nxt = w_asm_nxt;
          w_cnt_nxt   = r_cnt + (ADDR_W+1)'(1);
        end
      end
    end
  end

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign word_cnt_o   = r_cnt;
  assign load_err_o   = r_err;
  assign load_done_o  = (r_state == S_DONE);
  assign cpu_rst_o    = !((r_state == S_DONE) && !r_err);

endmodule
